// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its I-cache.
// Holds the chip reset level, the bubble (NOP) values presented on a
// fetch miss, I-cache geometry, and the fetch FSM state type.
package if_stage_pkg;

  // Level of rst_in that resets the chip.
  localparam logic        CHIP_RST = 1'b1;

  // Bubble injected toward IF_ID while the fetch is missing.
  localparam logic [31:0] NOP_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INS  = 32'h0000_0013;

  // Direct-mapped, one word per line: index = pc[7:2], tag = pc[31:8].
  localparam int unsigned ICACHE_LINES   = 64;
  localparam int unsigned ICACHE_INDEX_W = 6;
  localparam int unsigned ICACHE_TAG_W   = 32 - ICACHE_INDEX_W - 2;

  typedef logic [ICACHE_INDEX_W-1:0] icache_idx_t;
  typedef logic [ICACHE_TAG_W-1:0]   icache_tag_t;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_stage_icache.sv
// icache: direct-mapped instruction cache storage.
//   clk_i      in   clock
//   rst_i      in   synchronous reset; clears every valid bit only
//   rd_idx_i   in   lookup line index
//   rd_tag_i   in   lookup tag
//   hit_o      out  line valid and tag equal (combinational)
//   rd_data_o  out  word stored in the looked-up line (combinational)
//   we_i       in   fill strobe
//   wr_idx_i   in   fill line index
//   wr_tag_i   in   fill tag
//   wr_data_i  in   fill word
module icache
  import if_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  icache_idx_t rd_idx_i,
  input  icache_tag_t rd_tag_i,
  output logic        hit_o,
  output logic [31:0] rd_data_o,
  input  logic        we_i,
  input  icache_idx_t wr_idx_i,
  input  icache_tag_t wr_tag_i,
  input  logic [31:0] wr_data_i
);

  logic [31:0]             data_q  [ICACHE_LINES];
  icache_tag_t             tag_q   [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] valid_q;

  // Only the valid bits need a reset; stale data/tags are masked by them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      data_q[wr_idx_i] <= wr_data_i;
      tag_q[wr_idx_i]  <= wr_tag_i;
    end
  end

  assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with a 64-line direct-mapped I-cache.
//   clk_in        in   clock, rising edge
//   rst_in        in   synchronous reset (level CHIP_RST)
//   rdy_in        in   chip ready; low freezes pc, FSM, cache and request
//   stall         in   hold pc
//   jump          in   redirect pc to jump_target
//   jump_target   in   redirect pc
//   mem_req       out  fetch request, held until mem_valid
//   mem_addr      out  word-aligned fetch address
//   mem_valid     in   one-cycle pulse, mem_data valid
//   mem_data      in   fetched instruction word
//   if_pc         out  pc on hit, NOP_PC on miss
//   if_ins        out  cached word on hit, NOP_INS on miss
//   if_stall_req  out  high on miss
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_ins,
  output logic        if_stall_req
);

  logic        chip_rst;
  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        hit;
  logic [31:0] hit_data;
  logic        fill_we;

  assign chip_rst = (rst_in == CHIP_RST);

  // The fill uses the latched request address, not pc, so a jump taken
  // while waiting still fills the line that was actually requested.
  icache u_icache (
    .clk_i     (clk_in),
    .rst_i     (chip_rst),
    .rd_idx_i  (pc_q[ICACHE_INDEX_W+1:2]),
    .rd_tag_i  (pc_q[31:ICACHE_INDEX_W+2]),
    .hit_o     (hit),
    .rd_data_o (hit_data),
    .we_i      (fill_we),
    .wr_idx_i  (mem_addr_q[ICACHE_INDEX_W+1:2]),
    .wr_tag_i  (mem_addr_q[31:ICACHE_INDEX_W+2]),
    .wr_data_i (mem_data)
  );

  // State register
  always_ff @(posedge clk_in) begin
    if (chip_rst) begin
      state_q <= S_IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a miss with no redirect launches a fetch; the
  // returning word always ends the wait, whatever happened to pc.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (!hit && !jump) state_d = S_WAIT_MEM;
      S_WAIT_MEM: if (mem_valid)     state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req    = (state_q == S_WAIT_MEM);
    fill_we    = !chip_rst && rdy_in && (state_q == S_WAIT_MEM) && mem_valid;
    mem_addr_d = mem_addr_q;
    if ((state_q == S_IDLE) && !hit && !jump) begin
      mem_addr_d = {pc_q[31:2], 2'b00};
    end
    if (hit) begin
      if_pc        = pc_q;
      if_ins       = hit_data;
      if_stall_req = 1'b0;
    end else begin
      if_pc        = NOP_PC;
      if_ins       = NOP_INS;
      if_stall_req = 1'b1;
    end
  end

  // PC priority: jump, then stall, then advance on hit; a miss holds.
  always_comb begin
    pc_d = pc_q;
    if (jump) begin
      pc_d = jump_target;
    end else if (!stall && hit) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_in) begin
    if (chip_rst) begin
      pc_q       <= 32'h0000_0000;
      mem_addr_q <= 32'h0000_0000;
    end else if (rdy_in) begin
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_addr = mem_addr_q;

endmodule
